// File: rtl/core_trap_sequencer.sv
// Trap/xRET sequencer: writes xEPC/xCAUSE/xTVAL, pulses status stack, then issues a fetch redirect.
// Optional vectored trap targets for interrupts are enabled by defining TRAP_VECTORED_EN.
module core_trap_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_req_i,
    input  logic        trap_is_int_i,
    input  logic [4:0]  trap_cause_i,
    input  logic [31:0] trap_tval_i,
    input  logic        trap_to_s_i,
    input  logic [31:0] trap_pc_i,
    input  logic        xret_req_i,
    input  logic        xret_is_s_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] stvec_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] sepc_i,
    output logic        csr_wr_en_o,
    output logic [1:0]  csr_wr_sel_o,
    output logic        csr_wr_s_o,
    output logic [31:0] csr_wr_data_o,
    output logic        status_trap_o,
    output logic        status_xret_o,
    output logic        status_s_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        busy_o
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    localparam logic [1:0] SEL_EPC   = 2'd0;
    localparam logic [1:0] SEL_CAUSE = 2'd1;
    localparam logic [1:0] SEL_TVAL  = 2'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_EPC   = 3'd1,
        WR_CAUSE = 3'd2,
        WR_TVAL  = 3'd3,
        ST_TRAP  = 3'd4,
        XR_STAT  = 3'd5,
        REDIR    = 3'd6
    } state_e;

    state_e          state_q;
    logic            is_int_q;
    logic [4:0]      cause_q;
    logic [XLEN-1:0] tval_q;
    logic            to_s_q;
    logic [XLEN-1:0] pc_q;
    logic            xret_s_q;

    logic [XLEN-1:0] tvec_c;
    logic [XLEN-1:0] tvec_base_c;
    logic [XLEN-1:0] trap_target_c;
    logic [XLEN-1:0] xret_target_c;

    // Trap vector is sampled live in ST_TRAP, so late CSR writes are honoured.
    assign tvec_c      = to_s_q ? stvec_i : mtvec_i;
    assign tvec_base_c = tvec_c & ALIGN_MASK;
`ifdef TRAP_VECTORED_EN
    assign trap_target_c = ((tvec_c[1:0] == 2'b01) && is_int_q)
                         ? tvec_base_c + XLEN'({cause_q, 2'b00})
                         : tvec_base_c;
`else
    assign trap_target_c = tvec_base_c;
`endif
    assign xret_target_c = (xret_s_q ? sepc_i : mepc_i) & ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            is_int_q         <= 1'b0;
            cause_q          <= 5'd0;
            tval_q           <= '0;
            to_s_q           <= 1'b0;
            pc_q             <= '0;
            xret_s_q         <= 1'b0;
            csr_wr_en_o      <= 1'b0;
            csr_wr_sel_o     <= SEL_EPC;
            csr_wr_s_o       <= 1'b0;
            csr_wr_data_o    <= '0;
            status_trap_o    <= 1'b0;
            status_xret_o    <= 1'b0;
            status_s_o       <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            busy_o           <= 1'b0;
        end else begin
            // Write port and status pulses are idle unless the next state drives them.
            csr_wr_en_o   <= 1'b0;
            csr_wr_sel_o  <= SEL_EPC;
            csr_wr_s_o    <= 1'b0;
            csr_wr_data_o <= '0;
            status_trap_o <= 1'b0;
            status_xret_o <= 1'b0;
            status_s_o    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (trap_req_i) begin
                        state_q       <= WR_EPC;
                        is_int_q      <= trap_is_int_i;
                        cause_q       <= trap_cause_i;
                        tval_q        <= trap_tval_i;
                        to_s_q        <= trap_to_s_i;
                        pc_q          <= trap_pc_i;
                        csr_wr_en_o   <= 1'b1;
                        csr_wr_sel_o  <= SEL_EPC;
                        csr_wr_s_o    <= trap_to_s_i;
                        csr_wr_data_o <= trap_pc_i & ALIGN_MASK;
                        busy_o        <= 1'b1;
                    end else if (xret_req_i) begin
                        state_q       <= XR_STAT;
                        xret_s_q      <= xret_is_s_i;
                        status_xret_o <= 1'b1;
                        status_s_o    <= xret_is_s_i;
                        busy_o        <= 1'b1;
                    end
                end
                WR_EPC: begin
                    state_q       <= WR_CAUSE;
                    csr_wr_en_o   <= 1'b1;
                    csr_wr_sel_o  <= SEL_CAUSE;
                    csr_wr_s_o    <= to_s_q;
                    csr_wr_data_o <= {is_int_q, 26'd0, cause_q};
                end
                WR_CAUSE: begin
                    state_q       <= WR_TVAL;
                    csr_wr_en_o   <= 1'b1;
                    csr_wr_sel_o  <= SEL_TVAL;
                    csr_wr_s_o    <= to_s_q;
                    csr_wr_data_o <= tval_q;
                end
                WR_TVAL: begin
                    state_q       <= ST_TRAP;
                    status_trap_o <= 1'b1;
                    status_s_o    <= to_s_q;
                end
                ST_TRAP: begin
                    state_q          <= REDIR;
                    redirect_pc_o    <= trap_target_c;
                    redirect_valid_o <= 1'b1;
                end
                XR_STAT: begin
                    state_q          <= REDIR;
                    redirect_pc_o    <= xret_target_c;
                    redirect_valid_o <= 1'b1;
                end
                REDIR: begin
                    if (redirect_ready_i) begin
                        state_q          <= IDLE;
                        redirect_valid_o <= 1'b0;
                        busy_o           <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= IDLE;
                    redirect_valid_o <= 1'b0;
                    busy_o           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_trap_sequencer.sv
// Bench for core_trap_sequencer: directed and random trap/xRET sequences checked against a cycle-level reference.
module tb_core_trap_sequencer;

    logic        clk;
    logic        rst_n;
    logic        trap_req;
    logic        trap_is_int;
    logic [4:0]  trap_cause;
    logic [31:0] trap_tval;
    logic        trap_to_s;
    logic [31:0] trap_pc;
    logic        xret_req;
    logic        xret_is_s;
    logic [31:0] mtvec;
    logic [31:0] stvec;
    logic [31:0] mepc;
    logic [31:0] sepc;
    logic        csr_wr_en;
    logic [1:0]  csr_wr_sel;
    logic        csr_wr_s;
    logic [31:0] csr_wr_data;
    logic        status_trap;
    logic        status_xret;
    logic        status_s;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    int npass = 0;
    int ntot  = 0;

    core_trap_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .trap_req_i       (trap_req),
        .trap_is_int_i    (trap_is_int),
        .trap_cause_i     (trap_cause),
        .trap_tval_i      (trap_tval),
        .trap_to_s_i      (trap_to_s),
        .trap_pc_i        (trap_pc),
        .xret_req_i       (xret_req),
        .xret_is_s_i      (xret_is_s),
        .mtvec_i          (mtvec),
        .stvec_i          (stvec),
        .mepc_i           (mepc),
        .sepc_i           (sepc),
        .csr_wr_en_o      (csr_wr_en),
        .csr_wr_sel_o     (csr_wr_sel),
        .csr_wr_s_o       (csr_wr_s),
        .csr_wr_data_o    (csr_wr_data),
        .status_trap_o    (status_trap),
        .status_xret_o    (status_xret),
        .status_s_o       (status_s),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .redirect_ready_i (redirect_ready),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Reference trap target: direct base, or base + 4*cause for vectored interrupts.
    function automatic logic [31:0] ref_trap_target(input logic [31:0] tvec, input logic is_int,
                                                    input logic [4:0] cause);
        logic [31:0] t;
        t = tvec & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
        if (tvec[1:0] == 2'b01 && is_int) t = t + 32'(cause) * 32'd4;
`else
        if (is_int && cause == 5'd31) t = t + 32'd0;
`endif
        return t;
    endfunction

    task automatic scramble_csrs();
        mtvec = $urandom; stvec = $urandom; mepc = $urandom; sepc = $urandom;
    endtask

    task automatic redir_phase(input string tag, input logic [31:0] exp_pc, input int wt);
        for (int i = 0; i <= wt; i++) begin
            @(negedge clk);
            chk({tag, "_rvalid"}, 32'(redirect_valid), 32'd1);
            chk({tag, "_rpc"}, redirect_pc, exp_pc);
            chk({tag, "_rbusy"}, 32'(busy), 32'd1);
            scramble_csrs();
            if (i == wt) redirect_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_done_valid"}, 32'(redirect_valid), 32'd0);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        redirect_ready = 1'b0;
    endtask

    task automatic do_trap(input string tag, input logic is_int, input logic [4:0] cause,
                           input logic [31:0] tval, input logic [31:0] pc, input logic to_s,
                           input logic [31:0] mt, input logic [31:0] st, input int wt,
                           input logic sim_x, input logic noise);
        logic [31:0] exp_pc;
        exp_pc = ref_trap_target(to_s ? st : mt, is_int, cause);
        @(negedge clk);
        trap_req = 1'b1; trap_is_int = is_int; trap_cause = cause; trap_tval = tval;
        trap_pc = pc; trap_to_s = to_s; xret_req = sim_x; xret_is_s = 1'($urandom);
        scramble_csrs();
        @(negedge clk);
        chk({tag, "_epc_en"}, 32'(csr_wr_en), 32'd1);
        chk({tag, "_epc_sel"}, 32'(csr_wr_sel), 32'd0);
        chk({tag, "_epc_s"}, 32'(csr_wr_s), 32'(to_s));
        chk({tag, "_epc_data"}, csr_wr_data, pc & 32'hFFFF_FFFC);
        chk({tag, "_epc_busy"}, 32'(busy), 32'd1);
        chk({tag, "_epc_xret"}, 32'(status_xret), 32'd0);
        trap_req = noise; xret_req = noise; redirect_ready = noise;
        trap_is_int = 1'($urandom); trap_cause = 5'($urandom); trap_tval = $urandom;
        trap_pc = $urandom; trap_to_s = 1'($urandom);
        @(negedge clk);
        chk({tag, "_cause_en"}, 32'(csr_wr_en), 32'd1);
        chk({tag, "_cause_sel"}, 32'(csr_wr_sel), 32'd1);
        chk({tag, "_cause_s"}, 32'(csr_wr_s), 32'(to_s));
        chk({tag, "_cause_data"}, csr_wr_data, (32'(is_int) << 31) | 32'(cause));
        chk({tag, "_cause_xret"}, 32'(status_xret), 32'd0);
        @(negedge clk);
        chk({tag, "_tval_en"}, 32'(csr_wr_en), 32'd1);
        chk({tag, "_tval_sel"}, 32'(csr_wr_sel), 32'd2);
        chk({tag, "_tval_data"}, csr_wr_data, tval);
        trap_req = 1'b0; xret_req = 1'b0; redirect_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_st_trap"}, 32'(status_trap), 32'd1);
        chk({tag, "_st_s"}, 32'(status_s), 32'(to_s));
        chk({tag, "_st_en"}, 32'(csr_wr_en), 32'd0);
        chk({tag, "_st_xret"}, 32'(status_xret), 32'd0);
        chk({tag, "_st_rvalid"}, 32'(redirect_valid), 32'd0);
        mtvec = mt; stvec = st;
        redir_phase(tag, exp_pc, wt);
    endtask

    task automatic do_xret(input string tag, input logic is_s, input logic [31:0] me,
                           input logic [31:0] se, input int wt, input logic noise);
        @(negedge clk);
        xret_req = 1'b1; xret_is_s = is_s;
        scramble_csrs();
        @(negedge clk);
        chk({tag, "_xr_pulse"}, 32'(status_xret), 32'd1);
        chk({tag, "_xr_s"}, 32'(status_s), 32'(is_s));
        chk({tag, "_xr_trap"}, 32'(status_trap), 32'd0);
        chk({tag, "_xr_en"}, 32'(csr_wr_en), 32'd0);
        chk({tag, "_xr_busy"}, 32'(busy), 32'd1);
        xret_req = noise; trap_req = noise; xret_is_s = 1'($urandom);
        mepc = me; sepc = se;
        redir_phase(tag, (is_s ? se : me) & 32'hFFFF_FFFC, wt);
        xret_req = 1'b0; trap_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; trap_req = 1'b1; trap_is_int = 1'b0; trap_cause = 5'd0; trap_tval = '0;
        trap_to_s = 1'b0; trap_pc = '0; xret_req = 1'b1; xret_is_s = 1'b0;
        mtvec = '0; stvec = '0; mepc = '0; sepc = '0; redirect_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(csr_wr_en), 32'd0);
        chk("rst_trap", 32'(status_trap), 32'd0);
        chk("rst_xret", 32'(status_xret), 32'd0);
        chk("rst_rvalid", 32'(redirect_valid), 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        trap_req = 1'b0; xret_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        do_trap("exc", 1'b0, 5'd2, 32'h0000_1234, 32'h8000_0102, 1'b0,
                32'h8000_0400, 32'h1111_1111, 0, 1'b0, 1'b0);
        do_trap("vint", 1'b1, 5'd7, 32'h0, 32'h8000_0200, 1'b0,
                32'h8000_0401, 32'h0, 1, 1'b0, 1'b0);
        do_xret("sret", 1'b1, 32'h1234_5678, 32'h0040_0006, 0, 1'b0);
        do_trap("both", 1'b0, 5'd11, 32'hDEAD_BEEF, 32'h0000_0040, 1'b1,
                32'h0, 32'hC000_0003, 0, 1'b1, 1'b0);
        do_trap("stall", 1'b1, 5'd3, 32'h5, 32'h8000_0000, 1'b0,
                32'hFFFF_FFFD, 32'h0, 3, 1'b0, 1'b1);

        // Reset while writing CAUSE must squash the remainder of the sequence.
        @(negedge clk);
        trap_req = 1'b1; trap_is_int = 1'b0; trap_cause = 5'd4; trap_tval = 32'h99;
        trap_pc = 32'h100; trap_to_s = 1'b0;
        @(negedge clk);
        chk("abort_epc_en", 32'(csr_wr_en), 32'd1);
        trap_req = 1'b0;
        @(negedge clk);
        chk("abort_cause_sel", 32'(csr_wr_sel), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_rst_busy", 32'(busy), 32'd0);
        chk("abort_rst_en", 32'(csr_wr_en), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_quiet", {28'd0, csr_wr_en, status_trap, redirect_valid, busy}, 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0)
                do_xret("rnd_xret", 1'($urandom), $urandom, $urandom,
                        int'($urandom_range(0, 3)), 1'($urandom));
            else
                do_trap("rnd_trap", 1'($urandom), 5'($urandom), $urandom, $urandom,
                        1'($urandom), $urandom & 32'hFFFF_FFFD, $urandom,
                        int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
